frame_sync: RTL and testbench

- Receive-side frame synchroniser. Sits between the CDR output (data bit + bit-valid flag) and the outFIFO write port.
- Hunts for the 802.15.4 preamble and SFD, then extracts the PHR length byte.
- Forwards exactly length×8 payload bits into outFIFO. Drops noise between frames and aborts frames that stall.

---
 rtl/zigbee_rx_pkg.sv | 20 ++
 rtl/rx_watchdog.sv | 38 +++
 rtl/frame_sync.sv | 199 +++++++++++++++++++
 tb/tb_frame_sync.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zigbee_rx_pkg.sv
// Shared types and constants for the 802.15.4 receive-side frame synchroniser.
package zigbee_rx_pkg;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      SYNC    = 2'd1,
      PHR     = 2'd2,
      PAYLOAD = 2'd3
   } state_t;

   localparam logic [7:0] SFD_DEFAULT = 8'hA7;
   localparam int         PHR_LEN_W   = 7;
   localparam int         MAX_PSDU    = 127;
   localparam int         BITCNT_W    = 10;

   function automatic logic [BITCNT_W-1:0] len_to_bits(input logic [PHR_LEN_W-1:0] len);
      return {len, 3'b000};
   endfunction

endpackage

// File: rtl/rx_watchdog.sv
// Stall watchdog: counts cycles without a kick while enabled, one-cycle expire at TIMEOUT.
module rx_watchdog #(
   parameter int TIMEOUT = 64
) (
   input  logic inClock,
   input  logic inReset,
   input  logic kick,
   input  logic enable,
   output logic expire
);

   localparam logic [15:0] LAST_C = 16'(TIMEOUT - 1);

   logic [15:0] cnt_q, cnt_d;

   // A kick in the expiry cycle reloads the counter and suppresses the pulse.
   always_comb begin
      cnt_d  = cnt_q;
      expire = 1'b0;
      if (!enable || kick) begin
         cnt_d = 16'd0;
      end else if (cnt_q == LAST_C) begin
         expire = 1'b1;
         cnt_d  = 16'd0;
      end else begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge inClock or negedge inReset) begin
      if (!inReset) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/frame_sync.sv
// Frame synchroniser: preamble/SFD hunt, PHR length extraction and payload forwarding to outFIFO.
module frame_sync
   import zigbee_rx_pkg::*;
#(
   parameter int         PREAMBLE_MIN = 32,
   parameter logic [7:0] SFD          = SFD_DEFAULT,
   parameter int         MAX_LEN      = MAX_PSDU,
   parameter int         TIMEOUT      = 64
) (
   input  logic       inClock,
   input  logic       inReset,
   input  logic       inBit,
   input  logic       inBitValid,
   input  logic       inFifoFull,
   output logic       outWriteEnable,
   output logic       outData,
   output logic       outFrameStart,
   output logic       outFrameDone,
   output logic       outLengthError,
   output logic       outAbort,
   output logic       outOverflow,
   output logic [6:0] outLength,
   output logic [1:0] outState
);

   localparam logic [7:0]           PRE_MIN_C = 8'(PREAMBLE_MIN);
   localparam logic [PHR_LEN_W-1:0] MAX_LEN_C = PHR_LEN_W'(MAX_LEN);

   state_t                state_q, state_d;
   logic [7:0]            zero_cnt_q, zero_cnt_d;
   logic [6:0]            shift_q, shift_d;
   logic [2:0]            cap_cnt_q, cap_cnt_d;
   logic                  capturing_q, capturing_d;
   logic [BITCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [PHR_LEN_W-1:0]  length_q, length_d;
   logic                  we_q, we_d;
   logic                  data_q, data_d;
   logic                  start_q, start_d;
   logic                  done_q, done_d;
   logic                  lerr_q, lerr_d;
   logic                  abort_q, abort_d;
   logic                  ovf_q, ovf_d;

   logic                  wd_en_s;
   logic                  wd_expire_s;
   logic [7:0]            new_byte_s;
   logic [PHR_LEN_W-1:0]  len_s;

   // Only the last seven bits need storing; the eighth is the incoming bit itself.
   assign new_byte_s = {inBit, shift_q};
   assign len_s      = new_byte_s[PHR_LEN_W-1:0];
   assign wd_en_s    = ((state_q == SYNC) && capturing_q) || (state_q == PHR) || (state_q == PAYLOAD);

   rx_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .inClock (inClock),
      .inReset (inReset),
      .kick    (inBitValid),
      .enable  (wd_en_s),
      .expire  (wd_expire_s)
   );

   always_comb begin
      state_d     = state_q;
      zero_cnt_d  = zero_cnt_q;
      shift_d     = shift_q;
      cap_cnt_d   = cap_cnt_q;
      capturing_d = capturing_q;
      bit_cnt_d   = bit_cnt_q;
      length_d    = length_q;
      we_d        = 1'b0;
      data_d      = data_q;
      start_d     = 1'b0;
      done_d      = 1'b0;
      lerr_d      = 1'b0;
      abort_d     = 1'b0;
      ovf_d       = ovf_q;

      if (wd_expire_s) begin
         abort_d     = 1'b1;
         state_d     = HUNT;
         capturing_d = 1'b0;
         cap_cnt_d   = 3'd0;
      end else if (inBitValid) begin
         case (state_q)
            HUNT: begin
               if (inBit) begin
                  zero_cnt_d = 8'd0;
               end else if (zero_cnt_q + 8'd1 == PRE_MIN_C) begin
                  zero_cnt_d = 8'd0;
                  state_d    = SYNC;
               end else if (zero_cnt_q != 8'hFF) begin
                  zero_cnt_d = zero_cnt_q + 8'd1;
               end else begin
                  zero_cnt_d = zero_cnt_q;
               end
            end
            SYNC: begin
               // Zeros before the first one are still preamble and are not captured.
               if (capturing_q || inBit) begin
                  shift_d     = new_byte_s[7:1];
                  capturing_d = 1'b1;
                  cap_cnt_d   = cap_cnt_q + 3'd1;
                  if (cap_cnt_q == 3'd7) begin
                     capturing_d = 1'b0;
                     state_d     = (new_byte_s == SFD) ? PHR : HUNT;
                  end else begin
                     state_d = SYNC;
                  end
               end else begin
                  state_d = SYNC;
               end
            end
            PHR: begin
               shift_d   = new_byte_s[7:1];
               cap_cnt_d = cap_cnt_q + 3'd1;
               if (cap_cnt_q != 3'd7) begin
                  state_d = PHR;
               end else if ((len_s == '0) || (len_s > MAX_LEN_C)) begin
                  lerr_d  = 1'b1;
                  state_d = HUNT;
               end else begin
                  start_d   = 1'b1;
                  length_d  = len_s;
                  ovf_d     = 1'b0;
                  bit_cnt_d = len_to_bits(len_s);
                  state_d   = PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (inFifoFull) begin
                  ovf_d = 1'b1;
               end else begin
                  we_d   = 1'b1;
                  data_d = inBit;
               end
               bit_cnt_d = bit_cnt_q - 10'd1;
               if (bit_cnt_q == 10'd1) begin
                  done_d  = 1'b1;
                  state_d = HUNT;
               end else begin
                  state_d = PAYLOAD;
               end
            end
            default: begin
               state_d = HUNT;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   always_ff @(posedge inClock or negedge inReset) begin
      if (!inReset) begin
         state_q     <= HUNT;
         zero_cnt_q  <= 8'd0;
         shift_q     <= 7'd0;
         cap_cnt_q   <= 3'd0;
         capturing_q <= 1'b0;
         bit_cnt_q   <= '0;
         length_q    <= '0;
         we_q        <= 1'b0;
         data_q      <= 1'b0;
         start_q     <= 1'b0;
         done_q      <= 1'b0;
         lerr_q      <= 1'b0;
         abort_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         zero_cnt_q  <= zero_cnt_d;
         shift_q     <= shift_d;
         cap_cnt_q   <= cap_cnt_d;
         capturing_q <= capturing_d;
         bit_cnt_q   <= bit_cnt_d;
         length_q    <= length_d;
         we_q        <= we_d;
         data_q      <= data_d;
         start_q     <= start_d;
         done_q      <= done_d;
         lerr_q      <= lerr_d;
         abort_q     <= abort_d;
         ovf_q       <= ovf_d;
      end
   end

   assign outWriteEnable = we_q;
   assign outData        = data_q;
   assign outFrameStart  = start_q;
   assign outFrameDone   = done_q;
   assign outLengthError = lerr_q;
   assign outAbort       = abort_q;
   assign outOverflow    = ovf_q;
   assign outLength      = length_q;
   assign outState       = state_q;

endmodule

// File: tb/tb_frame_sync.sv
// Directed bench for frame_sync: a table of whole-frame scenarios plus a mid-payload reset sequence.
module tb_frame_sync;

   logic       inClock = 1'b0;
   logic       inReset;
   logic       inBit;
   logic       inBitValid;
   logic       inFifoFull;
   logic       outWriteEnable;
   logic       outData;
   logic       outFrameStart;
   logic       outFrameDone;
   logic       outLengthError;
   logic       outAbort;
   logic       outOverflow;
   logic [6:0] outLength;
   logic [1:0] outState;

   always #5 inClock = ~inClock;

   frame_sync dut (
      .inClock        (inClock),
      .inReset        (inReset),
      .inBit          (inBit),
      .inBitValid     (inBitValid),
      .inFifoFull     (inFifoFull),
      .outWriteEnable (outWriteEnable),
      .outData        (outData),
      .outFrameStart  (outFrameStart),
      .outFrameDone   (outFrameDone),
      .outLengthError (outLengthError),
      .outAbort       (outAbort),
      .outOverflow    (outOverflow),
      .outLength      (outLength),
      .outState       (outState)
   );

   typedef struct {
      string       name;
      bit          keep;       // no reset before this scenario
      int          bad_pre;    // zeros before a rejected 0xA6 SFD, 0 = none
      int          pre;
      logic [7:0]  sfd;
      logic [7:0]  phr;
      int          nbytes;
      logic [31:0] pay;        // byte0 in [7:0], sent LSB first
      int          full_lo;    // 1-based payload bit range with inFifoFull=1
      int          full_hi;
      int          stall_at;   // payload bit after which the line goes idle
      int          stall_len;
      int          e_start;
      int          e_lerr;
      int          e_abort;
      int          e_done;
      int          e_writes;
      int          e_len;
      int          e_ovf;
      int          e_maxst;
   } vec_t;

   int   n_err = 0;
   int   n_checks = 0;

   // Output monitor, sampled on the falling edge.
   logic mon_clr = 1'b0;
   int   n_start, n_lerr, n_abort, n_done, n_we, max_st, lat_err, we_at_done;
   logic prev_valid = 1'b0;
   logic got_bits[$];

   always @(negedge inClock) begin
      if (mon_clr) begin
         n_start    <= 0;
         n_lerr     <= 0;
         n_abort    <= 0;
         n_done     <= 0;
         n_we       <= 0;
         max_st     <= 0;
         lat_err    <= 0;
         we_at_done <= 0;
         got_bits.delete();
      end else begin
         if (outWriteEnable) begin
            n_we <= n_we + 1;
            got_bits.push_back(outData);
            if (!prev_valid) lat_err <= lat_err + 1;
         end
         if (outFrameStart)  n_start <= n_start + 1;
         if (outLengthError) n_lerr  <= n_lerr + 1;
         if (outAbort)       n_abort <= n_abort + 1;
         if (outFrameDone) begin
            n_done     <= n_done + 1;
            we_at_done <= outWriteEnable ? n_we + 1 : -1;
         end
         if (int'(outState) > max_st) max_st <= int'(outState);
      end
      prev_valid <= inBitValid;
   end

   task automatic chk(input string nm, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge inClock);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic full, input int idle);
      inBit      = b;
      inBitValid = 1'b1;
      inFifoFull = full;
      tick();
      inBit      = 1'b0;
      inBitValid = 1'b0;
      inFifoFull = 1'b0;
      repeat (idle) tick();
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_bit(v[i], 1'b0, 3);
   endtask

   task automatic send_zeros(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0, 3);
   endtask

   task automatic do_reset();
      inReset    = 1'b0;
      inBit      = 1'b0;
      inBitValid = 1'b0;
      inFifoFull = 1'b0;
      repeat (2) tick();
      inReset = 1'b1;
      tick();
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      tick();
      mon_clr = 1'b0;
   endtask

   function automatic vec_t mk(input string nm, input bit keep, input int bad_pre, input int pre,
                               input logic [7:0] sfd, input logic [7:0] phr, input int nb,
                               input logic [31:0] pay, input int flo, input int fhi,
                               input int sat, input int slen, input int es, input int el,
                               input int ea, input int ed, input int ew, input int elen,
                               input int eovf, input int emax);
      vec_t v;
      v.name = nm;       v.keep = keep;      v.bad_pre = bad_pre; v.pre = pre;
      v.sfd = sfd;       v.phr = phr;        v.nbytes = nb;       v.pay = pay;
      v.full_lo = flo;   v.full_hi = fhi;    v.stall_at = sat;    v.stall_len = slen;
      v.e_start = es;    v.e_lerr = el;      v.e_abort = ea;      v.e_done = ed;
      v.e_writes = ew;   v.e_len = elen;     v.e_ovf = eovf;      v.e_maxst = emax;
      return v;
   endfunction

   task automatic run_vec(input vec_t v);
      logic exp_bits[$];
      int   mism;
      logic full;
      int   idle;
      if (!v.keep) do_reset();
      clear_mon();
      if (v.bad_pre > 0) begin
         send_zeros(v.bad_pre);
         send_byte(8'hA6);
      end
      send_zeros(v.pre);
      send_byte(v.sfd);
      send_byte(v.phr);
      for (int i = 0; i < v.nbytes * 8; i++) begin
         full = ((i + 1) >= v.full_lo) && ((i + 1) <= v.full_hi);
         idle = ((i + 1) == v.stall_at) ? v.stall_len : 3;
         send_bit(v.pay[i], full, idle);
         if (!full) exp_bits.push_back(v.pay[i]);
      end
      repeat (8) tick();
      while (exp_bits.size() > v.e_writes) void'(exp_bits.pop_back());
      mism = 0;
      for (int i = 0; i < exp_bits.size() && i < got_bits.size(); i++)
         if (got_bits[i] != exp_bits[i]) mism++;
      chk({v.name, ".starts"},    n_start,        v.e_start);
      chk({v.name, ".len_errs"},  n_lerr,         v.e_lerr);
      chk({v.name, ".aborts"},    n_abort,        v.e_abort);
      chk({v.name, ".dones"},     n_done,         v.e_done);
      chk({v.name, ".writes"},    n_we,           v.e_writes);
      chk({v.name, ".data_bad"},  mism,           0);
      chk({v.name, ".latency"},   lat_err,        0);
      chk({v.name, ".done_at_wr"}, we_at_done,    v.e_done != 0 ? v.e_writes : 0);
      chk({v.name, ".length"},    int'(outLength), v.e_len);
      chk({v.name, ".overflow"},  int'(outOverflow), v.e_ovf);
      chk({v.name, ".end_state"}, int'(outState), 0);
      chk({v.name, ".max_state"}, max_st,         v.e_maxst);
   endtask

   vec_t vecs[9];

   initial begin
      //            name        keep bad pre  sfd    phr    nb payload        flo fhi sat slen st le ab dn wr len ovf mx
      vecs[0] = mk("basic",     0,   0, 32, 8'hA7, 8'h03, 3, 32'h00FF3CA5, 0, 0,  0,  0, 1, 0, 0, 1, 24, 3, 0, 3);
      vecs[1] = mk("short_pre", 0,   0, 31, 8'hA7, 8'h03, 3, 32'h00FF3CA5, 0, 0,  0,  0, 0, 0, 0, 0,  0, 0, 0, 0);
      // The rejected capture swallows one preamble zero, so 33 follow it.
      vecs[2] = mk("bad_sfd",   0,  32, 33, 8'hA7, 8'h03, 3, 32'h00FF3CA5, 0, 0,  0,  0, 1, 0, 0, 1, 24, 3, 0, 3);
      vecs[3] = mk("phr_00",    0,   0, 32, 8'hA7, 8'h00, 0, 32'h00000000, 0, 0,  0,  0, 0, 1, 0, 0,  0, 0, 0, 2);
      vecs[4] = mk("phr_80",    0,   0, 32, 8'hA7, 8'h80, 0, 32'h00000000, 0, 0,  0,  0, 0, 1, 0, 0,  0, 0, 0, 2);
      vecs[5] = mk("fifo_full", 0,   0, 32, 8'hA7, 8'h02, 2, 32'h0000C35A, 5, 8,  0,  0, 1, 0, 0, 1, 12, 2, 1, 3);
      vecs[6] = mk("next_frm",  1,   0, 32, 8'hA7, 8'h01, 1, 32'h00000081, 0, 0,  0,  0, 1, 0, 0, 1,  8, 1, 0, 3);
      vecs[7] = mk("stall_64",  0,   0, 32, 8'hA7, 8'h03, 3, 32'h00FF3CA5, 0, 0, 10, 64, 1, 0, 1, 0, 10, 3, 0, 3);
      vecs[8] = mk("stall_63",  0,   0, 32, 8'hA7, 8'h03, 3, 32'h00FF3CA5, 0, 0, 10, 63, 1, 0, 0, 1, 24, 3, 0, 3);

      do_reset();
      chk("reset.outputs", int'({outWriteEnable, outData, outFrameStart, outFrameDone, outLengthError,
                                 outAbort, outOverflow, outLength, outState}), 0);

      for (int k = 0; k < 9; k++) run_vec(vecs[k]);

      // Reset asserted right after the fifth payload write.
      do_reset();
      clear_mon();
      send_zeros(32);
      send_byte(8'hA7);
      send_byte(8'h03);
      send_bit(1'b1, 1'b0, 3);
      send_bit(1'b0, 1'b0, 3);
      send_bit(1'b1, 1'b0, 3);
      send_bit(1'b0, 1'b0, 3);
      send_bit(1'b0, 1'b0, 0);
      chk("rst_mid.pre_we",    int'(outWriteEnable), 1);
      chk("rst_mid.pre_state", int'(outState), 3);
      inReset = 1'b0;
      #1;
      chk("rst_mid.outputs", int'({outWriteEnable, outData, outFrameStart, outFrameDone, outLengthError,
                                   outAbort, outOverflow, outLength, outState}), 0);
      tick();
      inReset = 1'b1;
      clear_mon();
      for (int i = 5; i < 24; i++) send_bit(((32'h00FF3CA5 >> i) & 32'd1) != 32'd0, 1'b0, 3);
      repeat (8) tick();
      chk("rst_mid.writes", n_we,    0);
      chk("rst_mid.pulses", n_start + n_done + n_abort + n_lerr, 0);
      chk("rst_mid.state",  int'(outState), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
